// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU control codes,
// default widths and the control-code legality check.
package alu_arbiter_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CTL_W = 4;

    localparam logic [DEF_CTL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [DEF_CTL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [DEF_CTL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [DEF_CTL_W-1:0] ALU_SUB = 4'b0110;

    function automatic logic ctl_legal(input logic [DEF_CTL_W-1:0] ctl);
        return (ctl == ALU_ADD) || (ctl == ALU_SUB) ||
               (ctl == ALU_AND) || (ctl == ALU_OR);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters; sits between the issue and
// response registers of alu_arbiter.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CTL_W = DEF_CTL_W
) (
    input  logic [CTL_W-1:0] ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (ctl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters through a
// two-stage (issue, response) registered pipeline with valid/ready handshakes.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CTL_W = DEF_CTL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [CTL_W-1:0] req0_ctl,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [CTL_W-1:0] req1_ctl,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err
);

    logic             last_grant;
    logic             s1_valid;
    logic             s1_id;
    logic [CTL_W-1:0] s1_ctl;
    logic [WIDTH-1:0] s1_op1;
    logic [WIDTH-1:0] s1_op2;

    logic             adv1;
    logic             adv2;
    logic             hs0;
    logic             hs1;
    logic             s1_legal;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] res_next;

    assign adv2 = !rsp_valid || rsp_ready;
    assign adv1 = !s1_valid || adv2;

    // last_grant resets to 1 so requester 0 wins the first contest.
    assign hs0 = !reset && adv1 && req0_valid && (!req1_valid || last_grant);
    assign hs1 = !reset && adv1 && req1_valid && (!req0_valid || !last_grant);

    assign req0_ready = hs0;
    assign req1_ready = hs1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            s1_valid   <= 1'b0;
            s1_id      <= 1'b0;
            s1_ctl     <= '0;
            s1_op1     <= '0;
            s1_op2     <= '0;
        end else begin
            if (hs0) begin
                last_grant <= 1'b0;
                s1_valid   <= 1'b1;
                s1_id      <= 1'b0;
                s1_ctl     <= req0_ctl;
                s1_op1     <= req0_op1;
                s1_op2     <= req0_op2;
            end else if (hs1) begin
                last_grant <= 1'b1;
                s1_valid   <= 1'b1;
                s1_id      <= 1'b1;
                s1_ctl     <= req1_ctl;
                s1_op1     <= req1_op1;
                s1_op2     <= req1_op2;
            end else if (adv1) begin
                s1_valid   <= 1'b0;
            end
        end
    end

    alu_arbiter_alu #(
        .WIDTH (WIDTH),
        .CTL_W (CTL_W)
    ) u_alu (
        .ctl    (s1_ctl),
        .a      (s1_op1),
        .b      (s1_op2),
        .result (alu_result)
    );

    // Illegal codes are forced to zero here rather than trusting the ALU default.
    assign s1_legal = ctl_legal(s1_ctl);
    assign res_next = s1_legal ? alu_result : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (adv2) begin
            if (s1_valid) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= s1_id;
                rsp_result <= res_next;
                rsp_zero   <= (res_next == '0);
                rsp_err    <= !s1_legal;
            end else begin
                rsp_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a scoreboard queue filled at each issue
// handshake and drained at each response handshake, plus timing checks.
module tb_alu_arbiter;

    typedef struct packed {
        logic        id;
        logic        zero;
        logic        err;
        logic [63:0] result;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_ctl, req1_ctl;
    logic [63:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [63:0] rsp_result;

    int   total = 0;
    int   bad = 0;
    int   hs_count = 0;
    int   rsp_count = 0;
    int   grant_log[$];
    rsp_t exp_q[$];

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_ctl   (req0_ctl),
        .req0_op1   (req0_op1),
        .req0_op2   (req0_op2),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_ctl   (req1_ctl),
        .req1_op1   (req1_op1),
        .req1_op2   (req1_op2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    function automatic rsp_t model(input logic id, input logic [3:0] c,
                                   input logic [63:0] a, input logic [63:0] b);
        rsp_t r;
        r.id  = id;
        r.err = 1'b0;
        case (c)
            4'b0010: r.result = a + b;
            4'b0110: r.result = a - b;
            4'b0000: r.result = a & b;
            4'b0001: r.result = a | b;
            default: begin
                r.result = 64'd0;
                r.err    = 1'b1;
            end
        endcase
        r.zero = (r.result == 64'd0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Observe handshakes just before the next rising edge, then step past it.
    task automatic cycle();
        rsp_t e;
        @(negedge clk);
        if (req0_ready) begin
            exp_q.push_back(model(1'b0, req0_ctl, req0_op1, req0_op2));
            grant_log.push_back(0);
            hs_count++;
        end
        if (req1_ready) begin
            exp_q.push_back(model(1'b1, req1_ctl, req1_op1, req1_op2));
            grant_log.push_back(1);
            hs_count++;
        end
        if (rsp_valid && rsp_ready) begin
            rsp_count++;
            if (exp_q.size() == 0) begin
                chk("spurious_rsp", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp", {rsp_id, rsp_zero, rsp_err, rsp_result}, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    int          base_hs, base_rsp, issued;
    logic [66:0] held;

    initial begin
        req0_valid = 1'b1; req0_ctl = 4'b0010; req0_op1 = 64'd0; req0_op2 = 64'd0;
        req1_valid = 1'b0; req1_ctl = 4'b0010; req1_op1 = 64'd0; req1_op2 = 64'd0;
        rsp_ready  = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_fields", {rsp_id, rsp_zero, rsp_err, rsp_result}, 0);
        chk("rst_ready", req0_ready, 0);
        reset = 1'b0;
        req0_valid = 1'b0;
        @(posedge clk);
        #1;

        // single issue, latency 2
        req0_valid = 1'b1; req0_ctl = 4'b0010; req0_op1 = 64'd5; req0_op2 = 64'd7;
        #1;
        chk("t1_ready", req0_ready, 1);
        cycle();
        req0_valid = 1'b0;
        #1;
        chk("t1_no_early_rsp", rsp_valid, 0);
        cycle();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp", {rsp_id, rsp_zero, rsp_err, rsp_result}, {1'b0, 1'b0, 1'b0, 64'd12});
        repeat (2) cycle();

        // wrap and sub from requester 1
        base_hs = hs_count; base_rsp = rsp_count;
        req1_valid = 1'b1; req1_ctl = 4'b0110; req1_op1 = 64'd0; req1_op2 = 64'd1;
        cycle();
        req1_ctl = 4'b0010; req1_op1 = 64'hFFFF_FFFF_FFFF_FFFF; req1_op2 = 64'd1;
        cycle();
        req1_valid = 1'b0;
        repeat (3) cycle();
        chk("wrap_issued", hs_count - base_hs, 2);
        chk("wrap_delivered", rsp_count - base_rsp, 2);

        // contention: grants alternate starting at requester 0
        grant_log.delete();
        req0_valid = 1'b1; req0_ctl = 4'b0000; req0_op1 = 64'hF0; req0_op2 = 64'h0F;
        req1_valid = 1'b1; req1_ctl = 4'b0001; req1_op1 = 64'h1;  req1_op2 = 64'h2;
        repeat (6) cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) cycle();
        chk("cont_grants", grant_log.size(), 6);
        for (int i = 0; i < 6; i++) chk("cont_grant_order", grant_log[i], i % 2);

        // backpressure: rsp_ready low for cycles 2..5
        base_hs = hs_count; base_rsp = rsp_count;
        held = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            issued = hs_count - base_hs;
            rsp_ready  = !(cyc >= 2 && cyc <= 5);
            req0_valid = (issued < 4);
            req0_ctl   = 4'b0010;
            req0_op1   = 64'd1000 + 64'(issued);
            req0_op2   = 64'(issued);
            #1;
            if (cyc >= 2 && cyc <= 5) chk("bp_ready", {req0_ready, req1_ready}, 0);
            if (cyc == 2) held = {rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_result[62:0]};
            if (cyc >= 3 && cyc <= 5)
                chk("bp_hold", {rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_result[62:0]}, held);
            if (cyc == 5) chk("bp_accepted", hs_count - base_hs, 2);
            cycle();
        end
        req0_valid = 1'b0;
        rsp_ready  = 1'b1;
        chk("bp_issued", hs_count - base_hs, 4);
        chk("bp_delivered", rsp_count - base_rsp, 4);

        // illegal control code, then a legal one
        req0_valid = 1'b1; req0_ctl = 4'b0111; req0_op1 = 64'd3; req0_op2 = 64'd3;
        cycle();
        req0_valid = 1'b0;
        cycle();
        chk("ill_rsp", {rsp_valid, rsp_err, rsp_zero, rsp_result}, {1'b1, 1'b1, 1'b1, 64'd0});
        cycle();
        req0_valid = 1'b1; req0_ctl = 4'b0010;
        cycle();
        req0_valid = 1'b0;
        cycle();
        chk("ill_next_legal", {rsp_valid, rsp_err, rsp_result}, {1'b1, 1'b0, 64'd6});
        repeat (2) cycle();

        // reset while both stages are full
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_ctl = 4'b0010; req0_op1 = 64'd10; req0_op2 = 64'd20;
        cycle();
        req0_op1 = 64'd11; req0_op2 = 64'd21;
        cycle();
        chk("rst_pipe_full", {rsp_valid, req0_ready}, {1'b1, 1'b0});
        #3;
        reset = 1'b1;
        #1;
        chk("rst_async_clear", {rsp_valid, req0_ready}, 0);
        exp_q.delete();
        req1_valid = 1'b1; req1_ctl = 4'b0001; req1_op1 = 64'd1; req1_op2 = 64'd2;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_held", rsp_valid, 0);
        reset = 1'b0;
        rsp_ready = 1'b1;
        base_rsp = rsp_count;
        #1;
        chk("rst_first_grant", {req0_ready, req1_ready}, {1'b1, 1'b0});
        cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) cycle();
        chk("rst_no_stale", rsp_count - base_rsp, 1);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
